exe_mem_stage: RTL

- Registered stage directly downstream of the ALU.
- Captures the ALU result, the status flags and the memory/writeback controls of the instruction in EXE, and presents them to the MEM stage.
- Owns the architectural status register {N,Z,C,V}, which is updated only by S-suffixed instructions. Its C bit feeds back to the ALU carry input for ADC/SBC.
- Supports a downstream stall (freeze) and a squash of the EXE instruction (flush).

---
 rtl/exe_mem_stage.sv | 116 +++++++++++
 1 files changed

// File: rtl/exe_mem_stage.sv
// exe_mem_stage
//   EXE/MEM pipeline register placed directly after the ALU. Captures the ALU
//   result, store data, destination and memory/writeback controls of the
//   instruction in EXE, and owns the architectural {N,Z,C,V} status register.
//
// Ports
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   freeze           : MEM busy; hold every register
//   flush            : squash the instruction in EXE (bubble into MEM)
//   exe_valid        : EXE holds a real instruction
//   alu_result       : ALU result / memory address
//   alu_status       : ALU flags {N,Z,C,V}
//   s_bit            : instruction updates the status register
//   mem_read_in      : load
//   mem_write_in     : store
//   wb_en_in         : register writeback
//   dest_in          : destination register index
//   store_val_in     : store data
//   status_reg       : architectural {N,Z,C,V}
//   carry_out        : registered C flag, feeds the ALU carry input
//   mem_valid        : MEM holds a real instruction
//   mem_alu_result, mem_store_val, mem_dest, mem_read, mem_write, wb_en :
//                      registered values presented to MEM
module exe_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              flush,
    input  logic              exe_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_status,
    input  logic              s_bit,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              wb_en_in,
    input  logic [REG_AW-1:0] dest_in,
    input  logic [DATA_W-1:0] store_val_in,
    output logic [3:0]        status_reg,
    output logic              carry_out,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic [DATA_W-1:0] mem_store_val,
    output logic [REG_AW-1:0] mem_dest,
    output logic              mem_read,
    output logic              mem_write,
    output logic              wb_en
);

    logic              w_advance;
    logic [3:0]        r_status;
    logic              r_valid;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] r_store_val;
    logic [REG_AW-1:0] r_dest;
    logic              r_read;
    logic              r_write;
    logic              r_wb_en;

    assign w_advance = ~freeze & ~flush & exe_valid;

    // Pipeline register: freeze has priority over flush; a non-advancing,
    // non-frozen cycle loads a fully zeroed bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_result    <= '0;
            r_store_val <= '0;
            r_dest      <= '0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_wb_en     <= 1'b0;
        end else if (!freeze) begin
            if (w_advance) begin
                r_valid     <= 1'b1;
                r_result    <= alu_result;
                r_store_val <= store_val_in;
                r_dest      <= dest_in;
                r_read      <= mem_read_in;
                r_write     <= mem_write_in;
                r_wb_en     <= wb_en_in;
            end else begin
                r_valid     <= 1'b0;
                r_result    <= '0;
                r_store_val <= '0;
                r_dest      <= '0;
                r_read      <= 1'b0;
                r_write     <= 1'b0;
                r_wb_en     <= 1'b0;
            end
        end
    end

    // Status only changes when an S-suffixed instruction actually advances,
    // so a held instruction updates it exactly once and a squashed one never.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status <= '0;
        end else if (w_advance && s_bit) begin
            r_status <= alu_status;
        end
    end

    assign status_reg     = r_status;
    assign carry_out      = r_status[1];
    assign mem_valid      = r_valid;
    assign mem_alu_result = r_result;
    assign mem_store_val  = r_store_val;
    assign mem_dest       = r_dest;
    assign mem_read       = r_read;
    assign mem_write      = r_write;
    assign wb_en          = r_wb_en;

endmodule
